bus_mem_responder: RTL and testbench

- Memory-side target for the CPU's 16-bit instruction/data bus.
- Answers the fetch, argument and write-back cycles issued by the instruction decoder and program counter: read, write and locked sequential bursts.
- Serves the cycles from an internal single-port RAM, with a configurable number of wait states.
- Tristate resolution stays at top level: this block drives o_data_r and qualifies it with o_data_oe; the top level owns the bufif cells.

---
 rtl/cpu_bus_pkg.sv | 18 +
 rtl/bus_mem_responder_sp_ram.sv | 32 +++
 rtl/bus_mem_responder.sv | 148 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU 16-bit instruction/data bus.
// Used by the memory responder, the instruction decoder and the program counter.
package cpu_bus_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  // Bus direction as seen from the initiator.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/bus_mem_responder_sp_ram.sv
// Synchronous single-port RAM with registered read and write enable.
// The read is read-before-write; the array is never reset.
// Ports:
//   clk        clock
//   we_i       write enable, writes wdata_i to addr_i at the rising edge
//   addr_i     word address
//   wdata_i    write data
//   rdata_o    registered read data of addr_i from the previous edge
module sp_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side target of the CPU instruction/data bus. Serves read, write and
// locked sequential bursts from an internal single-port RAM with WAIT_STATES
// idle cycles between accept and response.
//
// state | meaning
// IDLE  | waiting for i_req; latches address, direction and write data
// WAIT  | counting wait states; i_req low aborts the beat
// DONE  | one-cycle response: o_ready, read data / write commit, o_err
//
// Ports:
//   clk, n_rst   clock, async active-low reset
//   i_req        bus cycle request
//   i_rw         0 read, 1 write (latched on accept)
//   i_lock       continue with a locked burst at address+1
//   i_addr       word address (latched on accept)
//   i_data_w     write data (latched on accept and on each locked beat)
//   o_data_r     read data, non-zero only in DONE of an in-range read
//   o_data_oe    responder drives the data bus (DONE of a read)
//   o_ready      beat completion strobe
//   o_err        beat address out of range, coincident with o_ready
//   o_busy       not IDLE
module bus_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_req,
  input  logic              i_rw,
  input  logic              i_lock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_w,
  output logic [DATA_W-1:0] o_data_r,
  output logic              o_data_oe,
  output logic              o_ready,
  output logic              o_err,
  output logic              o_busy
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
  localparam rsp_state_e FIRST_ST = (WAIT_STATES == 0) ? DONE : WAIT;

  rsp_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, addr_inc;
  logic                  rw_q, rw_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  in_range, is_done, ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign in_range = (addr_q >> DEPTH_LOG2) == '0;
  assign is_done  = (state_q == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          rw_d    = i_rw;
          wdata_d = i_data_w;
          cnt_d   = WS_INIT;
          state_d = FIRST_ST;
        end
      end
      WAIT: begin
        if (!i_req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Locked burst: direction stays latched, address auto-increments.
        if (i_req && i_lock) begin
          addr_d  = addr_inc;
          wdata_d = i_data_w;
          cnt_d   = WS_INIT;
          state_d = FIRST_ST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM read address must be valid one cycle before DONE. In DONE of a
  // read it points at the next burst word, which matters when WAIT_STATES=0.
  always_comb begin
    ram_addr = addr_q[DEPTH_LOG2-1:0];
    case (state_q)
      IDLE:    ram_addr = i_addr[DEPTH_LOG2-1:0];
      DONE:    ram_addr = (rw_q == RW_WRITE) ? addr_q[DEPTH_LOG2-1:0]
                                             : addr_inc[DEPTH_LOG2-1:0];
      default: ram_addr = addr_q[DEPTH_LOG2-1:0];
    endcase
  end

  assign ram_we = is_done && (rw_q == RW_WRITE) && in_range;

  sp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign o_ready   = is_done;
  assign o_err     = is_done && !in_range;
  assign o_data_oe = is_done && (rw_q == RW_READ);
  assign o_data_r  = (is_done && (rw_q == RW_READ) && in_range) ? ram_rdata : '0;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder. Two instances share clk/n_rst:
// index 0 has WAIT_STATES=0, index 1 has WAIT_STATES=1. Expected beats are
// queued when a transfer is driven and checked when o_ready appears.
module tb_bus_mem_responder;

  logic        clk;
  logic        n_rst;
  logic        req   [2];
  logic        rw_s  [2];
  logic        lock  [2];
  logic [15:0] addr_s[2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        oe    [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        busy  [2];

  int checks;
  int failures;
  int cyc;

  typedef struct {
    string       tag;
    int          d;
    logic [15:0] data;
    logic        err;
    logic        oe;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] model [2][1024];

  bus_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .i_req(req[0]), .i_rw(rw_s[0]), .i_lock(lock[0]),
    .i_addr(addr_s[0]), .i_data_w(wdata[0]), .o_data_r(rdata[0]),
    .o_data_oe(oe[0]), .o_ready(rdy[0]), .o_err(err[0]), .o_busy(busy[0])
  );

  bus_mem_responder #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .i_req(req[1]), .i_rw(rw_s[1]), .i_lock(lock[1]),
    .i_addr(addr_s[1]), .i_data_w(wdata[1]), .o_data_r(rdata[1]),
    .o_data_oe(oe[1]), .o_ready(rdy[1]), .o_err(err[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard side: every o_ready pops one expected beat.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rdy[g]) begin
        if (sb.size() == 0) begin
          checks++;
          assert (rdy[g] === 1'b0) else begin
            failures++;
            $error("FAIL unexpected_ready dut%0d got=%b exp=0", g, rdy[g]);
          end
        end else begin
          e = sb.pop_front();
          checks++;
          assert (e.d === g) else begin
            failures++;
            $error("FAIL %s_dut got=%0d exp=%0d", e.tag, g, e.d);
          end
          checks++;
          assert (cyc === e.cyc) else begin
            failures++;
            $error("FAIL %s_latency got_cyc=%0d exp_cyc=%0d", e.tag, cyc, e.cyc);
          end
          checks++;
          assert (err[g] === e.err) else begin
            failures++;
            $error("FAIL %s_err got=%b exp=%b", e.tag, err[g], e.err);
          end
          checks++;
          assert (oe[g] === e.oe) else begin
            failures++;
            $error("FAIL %s_oe got=%b exp=%b", e.tag, oe[g], e.oe);
          end
          if (e.oe) begin
            checks++;
            assert (rdata[g] === e.data) else begin
              failures++;
              $error("FAIL %s_data got=%h exp=%h", e.tag, rdata[g], e.data);
            end
          end
        end
      end else begin
        checks++;
        assert ({oe[g], err[g]} === 2'b00) else begin
          failures++;
          $error("FAIL idle_strobes dut%0d got oe/err=%b%b exp=00", g, oe[g], err[g]);
        end
      end
    end
  end

  // One transfer of `beats` beats (locked when beats>1) on instance d.
  // Instance index equals its WAIT_STATES value.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wd, input int beats, input string tag);
    int          ws;
    int          base;
    int          per;
    int          k;
    logic [15:0] a;
    exp_t        x;
    ws  = d;
    per = ws + 1;
    @(negedge clk);
    base      = cyc;
    req[d]    = 1'b1;
    rw_s[d]   = wr;
    lock[d]   = (beats > 1);
    addr_s[d] = addr;
    wdata[d]  = wd;
    for (int b = 0; b < beats; b++) begin
      a     = addr + 16'(b);
      x.tag = tag;
      x.d   = d;
      x.err = (a >= 16'd1024);
      x.oe  = !wr;
      x.cyc = base + (b + 1) * per;
      x.data = (x.err || wr) ? 16'h0000 : model[d][a[9:0]];
      if (wr && !x.err) model[d][a[9:0]] = wd + 16'(b);
      sb.push_back(x);
    end
    for (int n = 1; n <= beats * per; n++) begin
      @(negedge clk);
      addr_s[d] = 16'hDEAD ^ 16'(n);
      rw_s[d]   = ~wr;
      if (n % per == 0) begin
        k        = n / per - 1;
        wdata[d] = wd + 16'(k + 1);
        if (k == beats - 1) begin
          req[d]  = 1'b0;
          lock[d] = 1'b0;
        end
      end else if (n > (beats - 1) * per) begin
        lock[d] = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("FAIL %s_missing_ready got_pending=%0d exp=0", tag, sb.size());
      sb.delete();
    end
    checks++;
    assert (busy[d] === 1'b0) else begin
      failures++;
      $error("FAIL %s_busy_after got=%b exp=0", tag, busy[d]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    n_rst    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; rw_s[g] = 1'b0; lock[g] = 1'b0;
      addr_s[g] = 16'h0000; wdata[g] = 16'h0000;
    end
    #3;
    for (int g = 0; g < 2; g++) begin
      checks++;
      assert ({rdy[g], err[g], oe[g], busy[g], rdata[g]} === 20'h0) else begin
        failures++;
        $error("FAIL reset_outputs dut%0d got=%h exp=0",
               g, {rdy[g], err[g], oe[g], busy[g], rdata[g]});
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single write then read, one wait state.
    xfer(1, 1'b1, 16'h0005, 16'h1234, 1, "wr5");
    xfer(1, 1'b0, 16'h0005, 16'h0000, 1, "rd5");

    // Preload via a locked write burst, then a locked read burst.
    xfer(1, 1'b1, 16'h0010, 16'h00A0, 4, "wrburst");
    xfer(1, 1'b0, 16'h0010, 16'h0000, 4, "rdburst");

    // Out-of-range accesses.
    xfer(1, 1'b1, 16'h0000, 16'h0F0F, 1, "wr0");
    xfer(1, 1'b1, 16'h0400, 16'h5A5A, 1, "wr400_oor");
    xfer(1, 1'b0, 16'h0000, 16'h0000, 1, "rd0");
    xfer(1, 1'b0, 16'h0400, 16'h0000, 1, "rd400_oor");

    // Abort during WAIT.
    xfer(1, 1'b1, 16'h0020, 16'h5555, 1, "wr20");
    @(negedge clk);
    req[1] = 1'b1; rw_s[1] = 1'b1; addr_s[1] = 16'h0020; wdata[1] = 16'hBEEF;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    assert (busy[1] === 1'b0) else begin
      failures++;
      $error("FAIL abort_idle got_busy=%b exp=0", busy[1]);
    end
    xfer(1, 1'b0, 16'h0020, 16'h0000, 1, "rd20_after_abort");

    // Reset while in DONE of a write.
    @(negedge clk);
    req[1] = 1'b1; rw_s[1] = 1'b1; addr_s[1] = 16'h0005; wdata[1] = 16'h9999;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    assert (rdy[1] === 1'b1) else begin
      failures++;
      $error("FAIL rst_pre_done got_ready=%b exp=1", rdy[1]);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    assert ({rdy[1], err[1], oe[1], busy[1], rdata[1]} === 20'h0) else begin
      failures++;
      $error("FAIL rst_mid_done got=%h exp=0", {rdy[1], err[1], oe[1], busy[1], rdata[1]});
    end
    req[1] = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    xfer(1, 1'b0, 16'h0005, 16'h0000, 1, "rd5_after_rst");

    // Zero wait states: single beats and a wrapping locked write burst.
    xfer(0, 1'b1, 16'h0003, 16'hC0DE, 1, "ws0_wr3");
    xfer(0, 1'b0, 16'h0003, 16'h0000, 1, "ws0_rd3");
    xfer(0, 1'b1, 16'hFFFF, 16'h7777, 2, "ws0_wrap");
    xfer(0, 1'b0, 16'h0000, 16'h0000, 1, "ws0_rd0");
    xfer(0, 1'b1, 16'h0040, 16'h0300, 3, "ws0_wrburst");
    xfer(0, 1'b0, 16'h0040, 16'h0000, 3, "ws0_rdburst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
